// File: rtl/seq_shifter_if.sv
// Request/result handshake bundle for seq_shifter: valid/ready on the operand side
// and on the result side. The master drives requests; the slave is the shifter.
interface seq_shifter_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] shift_in;
    logic [2:0]       shift_op;
    logic [AMT_W-1:0] shift_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] shift_out;
    logic             carry_out;

    modport master (
        output in_valid, shift_in, shift_op, shift_amt, out_ready,
        input  in_ready, out_valid, shift_out, carry_out
    );

    modport slave (
        input  in_valid, shift_in, shift_op, shift_amt, out_ready,
        output in_ready, out_valid, shift_out, carry_out
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: LSL/LSR/ASR by a runtime amount, up to STEP bits per clock,
// with carry-out. Define SHIFT_ROR_EN to add rotate-right on op 100.
module seq_shifter #(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    seq_shifter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [1:0] {K_LSL, K_LSR, K_ASR, K_ROR} kind_t;

    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    state_t           state_q;
    kind_t            kind_q;
    logic [WIDTH-1:0] work_q;
    logic             carry_q;
    logic [AMT_W-1:0] rem_q;
    logic             out_valid_q;
    logic             in_ready_q;

    kind_t            acc_kind;
    logic             acc_active;
    logic [WIDTH-1:0] work_d;
    logic             carry_d;
    logic [AMT_W-1:0] rem_d;

    // Returns {bit leaving the register, shifted value} for a single-bit move.
    function automatic logic [WIDTH:0] shift_one(input kind_t k, input logic [WIDTH-1:0] v);
        case (k)
            K_LSL:   return {v, 1'b0};
            K_LSR:   return {v[0], 1'b0, v[WIDTH-1:1]};
            K_ASR:   return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: return {v[0], v[0], v[WIDTH-1:1]};
        endcase
    endfunction

    always_comb begin
        acc_kind   = K_LSL;
        acc_active = 1'b0;
        case (bus.shift_op)
            3'b001: begin acc_kind = K_LSL; acc_active = 1'b1; end
            3'b010: begin acc_kind = K_LSR; acc_active = 1'b1; end
            3'b011: begin acc_kind = K_ASR; acc_active = 1'b1; end
`ifdef SHIFT_ROR_EN
            3'b100: begin acc_kind = K_ROR; acc_active = 1'b1; end
`endif
            default: ;
        endcase
        if (bus.shift_amt == '0) acc_active = 1'b0;
    end

    // One clock of work: a chain of single-bit moves, each gated by the remaining count.
    always_comb begin
        work_d  = work_q;
        carry_d = carry_q;
        for (int i = 0; i < STEP; i++) begin
            if (AMT_W'(i) < rem_q) {carry_d, work_d} = shift_one(kind_q, work_d);
        end
        rem_d = (rem_q > STEP_A) ? rem_q - STEP_A : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            kind_q      <= K_LSL;
            work_q      <= '0;
            carry_q     <= 1'b0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        work_q     <= bus.shift_in;
                        carry_q    <= 1'b0;
                        kind_q     <= acc_kind;
                        in_ready_q <= 1'b0;
                        if (acc_active) begin
                            rem_q   <= bus.shift_amt;
                            state_q <= S_SHIFT;
                        end else begin
                            rem_q       <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    work_q  <= work_d;
                    carry_q <= carry_d;
                    rem_q   <= rem_d;
                    if (rem_d == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.shift_out = work_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=4 instances driven in lockstep, checked each
// cycle against a reference model and against hand-computed expectations.
module tb_seq_shifter;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid, out_ready;
    logic [W-1:0]  din;
    logic [2:0]    op;
    logic [3:0]    amt;

    seq_shifter_if #(.WIDTH(W)) b1 ();
    seq_shifter_if #(.WIDTH(W)) b4 ();

    seq_shifter #(.WIDTH(W), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    seq_shifter #(.WIDTH(W), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    assign b1.in_valid = in_valid;  assign b4.in_valid = in_valid;
    assign b1.shift_in = din;       assign b4.shift_in = din;
    assign b1.shift_op = op;        assign b4.shift_op = op;
    assign b1.shift_amt = amt;      assign b4.shift_amt = amt;
    assign b1.out_ready = out_ready; assign b4.out_ready = out_ready;

    logic [W-1:0] so [2];
    logic         co [2];
    logic         ov [2];
    logic         ir [2];
    assign so[0] = b1.shift_out; assign so[1] = b4.shift_out;
    assign co[0] = b1.carry_out; assign co[1] = b4.carry_out;
    assign ov[0] = b1.out_valid; assign ov[1] = b4.out_valid;
    assign ir[0] = b1.in_ready;  assign ir[1] = b4.in_ready;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: the single-cycle result of the operation, as {carry, value}.
    function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] x, input int a);
        logic [W-1:0] r;
        if (a == 0) return {1'b0, x};
        case (o)
            3'd1: begin r = x << a; return {x[W-a], r}; end
            3'd2: begin r = x >> a; return {x[a-1], r}; end
            3'd3: begin r = W'($signed(x) >>> a); return {x[a-1], r}; end
`ifdef SHIFT_ROR_EN
            3'd4: begin r = (x >> a) | (x << (W - a)); return {r[W-1], r}; end
`endif
            default: return {1'b0, x};
        endcase
    endfunction

    function automatic logic is_shift(input logic [2:0] o, input int a);
`ifdef SHIFT_ROR_EN
        return (o >= 3'd1 && o <= 3'd4) && a != 0;
`else
        return (o >= 3'd1 && o <= 3'd3) && a != 0;
`endif
    endfunction

    function automatic int stepof(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    logic [W:0] m_val;
    logic       m_act;
    always_comb begin
        m_val = model(op, din, int'(amt));
        m_act = is_shift(op, int'(amt));
    end

    logic         busy  [2];
    logic         fresh [2];
    int           cnt   [2];
    int           lat   [2];
    logic [W-1:0] eres  [2];
    logic         ecar  [2];

    // Model bookkeeping: cnt counts edges since the accept edge (accept edge = 1).
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                busy[i]  <= 1'b0;
                fresh[i] <= 1'b1;
                cnt[i]   <= 0;
            end else if (!busy[i]) begin
                if (in_valid) begin
                    busy[i]  <= 1'b1;
                    fresh[i] <= 1'b0;
                    cnt[i]   <= 1;
                    lat[i]   <= 1 + (m_act ? (int'(amt) + stepof(i) - 1) / stepof(i) : 0);
                    eres[i]  <= m_val[W-1:0];
                    ecar[i]  <= m_val[W];
                end
            end else if (cnt[i] >= lat[i]) begin
                if (out_ready) busy[i] <= 1'b0;
            end else begin
                cnt[i] <= cnt[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!busy[i]) begin
                chk($sformatf("dut%0d.in_ready idle", i), 32'(ir[i]), 32'd1);
                chk($sformatf("dut%0d.out_valid idle", i), 32'(ov[i]), 32'd0);
                if (fresh[i]) begin
                    chk($sformatf("dut%0d.shift_out reset", i), 32'(so[i]), 32'd0);
                    chk($sformatf("dut%0d.carry_out reset", i), 32'(co[i]), 32'd0);
                end
            end else if (cnt[i] >= lat[i]) begin
                chk($sformatf("dut%0d.in_ready done", i), 32'(ir[i]), 32'd0);
                chk($sformatf("dut%0d.out_valid done", i), 32'(ov[i]), 32'd1);
                chk($sformatf("dut%0d.shift_out", i), 32'(so[i]), 32'(eres[i]));
                chk($sformatf("dut%0d.carry_out", i), 32'(co[i]), 32'(ecar[i]));
            end else begin
                chk($sformatf("dut%0d.in_ready busy", i), 32'(ir[i]), 32'd0);
                chk($sformatf("dut%0d.out_valid busy", i), 32'(ov[i]), 32'd0);
            end
        end
    end

    // One transaction with literal expectations for both instances.
    task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [3:0] a,
                       input logic [W-1:0] er, input logic ec, input int l1, input int l4,
                       input int hold);
        int seen [2];
        seen[0] = 0;
        seen[1] = 0;
        @(negedge clk);
        in_valid = 1'b1; op = o; din = x; amt = a;
        @(negedge clk);
        in_valid = 1'b0; din = W'($urandom); op = 3'($urandom); amt = 4'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (ov[0] && seen[0] == 0) seen[0] = c;
            if (ov[1] && seen[1] == 0) seen[1] = c;
            if (seen[0] != 0 && seen[1] != 0) break;
            @(negedge clk);
        end
        chk("latency step1", 32'(seen[0]), 32'(l1));
        chk("latency step4", 32'(seen[1]), 32'(l4));
        chk("result step1", 32'(so[0]), 32'(er));
        chk("carry step1", 32'(co[0]), 32'(ec));
        chk("result step4", 32'(so[1]), 32'(er));
        chk("carry step4", 32'(co[1]), 32'(ec));
        if (hold > 0) begin
            in_valid = 1'b1; din = 16'hA5A5; op = 3'b001; amt = 4'd2;
            repeat (hold) @(negedge clk);
            chk("held result step1", 32'(so[0]), 32'(er));
            chk("held result step4", 32'(so[1]), 32'(er));
            chk("held in_ready step1", 32'(ir[0]), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready after drain step1", 32'(ir[0]), 32'd1);
        chk("in_ready after drain step4", 32'(ir[1]), 32'd1);
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; din = '0; op = '0; amt = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", 32'(ir[0]), 32'd1);
        chk("reset out_valid", 32'(ov[0]), 32'd0);
        #2 rst = 1'b0;

        run(3'b001, 16'h8001, 4'd1,  16'h0002, 1'b1,  2, 2, 0);
        run(3'b011, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 16, 5, 0);
        run(3'b010, 16'h8000, 4'd15, 16'h0001, 1'b0, 16, 5, 0);
        run(3'b010, 16'hF0F1, 4'd9,  16'h0078, 1'b0, 10, 4, 5);
        run(3'b000, 16'hF0F1, 4'd7,  16'hF0F1, 1'b0,  1, 1, 0);
        run(3'b001, 16'hFFFF, 4'd15, 16'h8000, 1'b1, 16, 5, 0);
        run(3'b011, 16'h8421, 4'd5,  16'hFC21, 1'b0,  6, 3, 0);
        run(3'b010, 16'h00FF, 4'd4,  16'h000F, 1'b1,  5, 2, 0);
        run(3'b111, 16'h1234, 4'd5,  16'h1234, 1'b0,  1, 1, 0);
        run(3'b001, 16'h1234, 4'd0,  16'h1234, 1'b0,  1, 1, 0);
`ifdef SHIFT_ROR_EN
        run(3'b100, 16'h0001, 4'd1,  16'h8000, 1'b1,  2, 2, 0);
`else
        run(3'b100, 16'h0001, 4'd1,  16'h0001, 1'b0,  1, 1, 0);
`endif

        // Reset in the middle of a long shift.
        @(negedge clk);
        in_valid = 1'b1; op = 3'b001; din = 16'h1234; amt = 4'd12;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async reset in_ready step1", 32'(ir[0]), 32'd1);
        chk("async reset out_valid step1", 32'(ov[0]), 32'd0);
        chk("async reset shift_out step1", 32'(so[0]), 32'd0);
        chk("async reset carry step1", 32'(co[0]), 32'd0);
        chk("async reset out_valid step4", 32'(ov[1]), 32'd0);
        chk("async reset shift_out step4", 32'(so[1]), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        run(3'b001, 16'h0001, 4'd3, 16'h0008, 1'b0, 4, 2, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
